// File: rtl/i2s_pkg.sv
// Shared types for the I2S rate sequencer.
// Rate codes, sequencer states and reset defaults.
package i2s_pkg;

    typedef enum logic [1:0] {
        RATE_38K     = 2'd0,
        RATE_72K     = 2'd1,
        RATE_152K    = 2'd2,
        RATE_ILLEGAL = 2'd3
    } aud_rate_t;

    typedef enum logic [2:0] {
        ST_BOOT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_MUTE_WAIT = 3'd2,
        ST_HOLD      = 3'd3,
        ST_SETTLE    = 3'd4
    } rate_seq_state_t;

    localparam aud_rate_t AUD_RATE_RESET = RATE_38K;

endpackage

// File: rtl/i2s_frame_tick.sv
// Word-clock edge detector plus per-wait timeout counter.
// Edges are masked while the clock generator is held in reset.
module i2s_frame_tick #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic wclk,
    input  logic gate,
    input  logic wait_en,
    input  logic restart,
    output logic rise,
    output logic fall,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic          wclk_q;
    logic [TW-1:0] cnt_q, cnt_d;

    assign rise   = wclk & ~wclk_q & ~gate;
    assign fall   = ~wclk & wclk_q & ~gate;
    assign expire = wait_en && (cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Counter idles at zero, so every wait starts from a fresh budget.
    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (!wait_en || restart || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wclk_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            wclk_q <= wclk;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/i2s_rate_seq.sv
// Click-free sample-rate switch sequencer for the I2S clock generator.
// Mute, wait frame end, hold generator in reset, apply rate, settle, unmute.
module i2s_rate_seq
    import i2s_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned SETTLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_rate,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       wclk,
    output logic [1:0] aud_rate,
    output logic       i2s_reset,
    output logic       mute,
    output logic       done,
    output logic       rate_err,
    output logic       timeout
);

    rate_seq_state_t state_q, state_d;
    logic [1:0] aud_rate_q, aud_rate_d;
    logic [1:0] pending_q, pending_d;
    logic       mute_q, mute_d;
    logic       i2s_reset_q, i2s_reset_d;
    logic       req_ready_q, req_ready_d;
    logic       done_q, done_d;
    logic       rate_err_q, rate_err_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] frame_cnt_q, frame_cnt_d;

    logic wait_en, rise, fall, expire, tick_ev, accept;

    assign wait_en = (state_q == ST_BOOT) || (state_q == ST_MUTE_WAIT)
                  || (state_q == ST_SETTLE);
    // A timeout stands in for the awaited edge.
    assign tick_ev = wait_en
                  && (((state_q == ST_MUTE_WAIT) ? fall : rise) || expire);
    assign accept  = req_valid && req_ready_q;

    i2s_frame_tick #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .wclk   (wclk),
        .gate   (i2s_reset_q),
        .wait_en(wait_en),
        .restart(tick_ev),
        .rise   (rise),
        .fall   (fall),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        aud_rate_d  = aud_rate_q;
        pending_d   = pending_q;
        mute_d      = mute_q;
        i2s_reset_d = i2s_reset_q;
        done_d      = 1'b0;
        rate_err_d  = 1'b0;
        timeout_d   = timeout_q || (tick_ev && expire);
        hold_cnt_d  = hold_cnt_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_BOOT, ST_SETTLE: begin
                if (tick_ev) begin
                    if (frame_cnt_q == 4'(SETTLE_FRAMES - 1)) begin
                        frame_cnt_d = '0;
                        mute_d      = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    if (req_rate == RATE_ILLEGAL) begin
                        rate_err_d = 1'b1;
                    end else if (req_rate == aud_rate_q) begin
                        done_d = 1'b1;
                    end else begin
                        pending_d = req_rate;
                        mute_d    = 1'b1;
                        state_d   = ST_MUTE_WAIT;
                    end
                end
            end
            ST_MUTE_WAIT: begin
                if (tick_ev) begin
                    i2s_reset_d = 1'b1;
                    aud_rate_d  = pending_q;
                    hold_cnt_d  = '0;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == 8'(HOLD_CYCLES - 1)) begin
                    i2s_reset_d = 1'b0;
                    hold_cnt_d  = '0;
                    state_d     = ST_SETTLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_BOOT;
        endcase
        req_ready_d = (state_d == ST_IDLE) && !accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            aud_rate_q  <= AUD_RATE_RESET;
            pending_q   <= AUD_RATE_RESET;
            mute_q      <= 1'b1;
            i2s_reset_q <= 1'b0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            rate_err_q  <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            aud_rate_q  <= aud_rate_d;
            pending_q   <= pending_d;
            mute_q      <= mute_d;
            i2s_reset_q <= i2s_reset_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            rate_err_q  <= rate_err_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign aud_rate  = aud_rate_q;
    assign i2s_reset = i2s_reset_q;
    assign mute      = mute_q;
    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign rate_err  = rate_err_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_i2s_rate_seq.sv
// Self-checking bench for i2s_rate_seq against a timeline model.
// The bench plays the clock generator, so it knows every wclk edge.
module tb_i2s_rate_seq;

    localparam int HOLD = 4;
    localparam int SETTLE = 2;
    localparam int TO = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req_rate = 2'd0;
    logic       req_valid = 1'b0;
    logic       wclk = 1'b0;
    logic       req_ready, i2s_reset, mute, done, rate_err, timeout;
    logic [1:0] aud_rate;

    logic       e_ready, e_mute, e_rst, e_done, e_err, e_to;
    logic [1:0] e_rate;
    int  n_cmp = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  wph = 0;
    bit  whold = 1'b0;
    bit  rose, fell;

    i2s_rate_seq #(
        .HOLD_CYCLES(HOLD),
        .SETTLE_FRAMES(SETTLE),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_rate(req_rate), .req_valid(req_valid),
        .req_ready(req_ready), .wclk(wclk),
        .aud_rate(aud_rate), .i2s_reset(i2s_reset),
        .mute(mute), .done(done),
        .rate_err(rate_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic int per(input logic [1:0] r);
        case (r)
            2'd0:    return 256;
            2'd1:    return 136;
            default: return 64;
        endcase
    endfunction

    task automatic chk(input string tag);
        logic [7:0] o, e;
        o = {req_ready, mute, i2s_reset, aud_rate, done, rate_err, timeout};
        e = {e_ready, e_mute, e_rst, e_rate, e_done, e_err, e_to};
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s cyc=%0d obs=%b exp=%b (rdy,mute,rst,rate,done,err,to)",
                   tag, cyc, o, e);
        end
    endtask

    // Behaviour of the clock generator: held low in reset, free-running otherwise.
    task automatic drive_wclk();
        logic prev;
        prev = wclk;
        if (e_rst) begin
            wclk = 1'b0;
            wph = 0;
        end else if (whold) begin
            wclk = 1'b0;
        end else begin
            wph = (wph + 1) % per(e_rate);
            wclk = (wph >= per(e_rate) / 2);
        end
        rose = wclk && !prev;
        fell = !wclk && prev;
    endtask

    task automatic tick();
        drive_wclk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_reset_exp();
        e_ready = 1'b0; e_mute = 1'b1; e_rst = 1'b0;
        e_rate = 2'd0; e_done = 1'b0; e_err = 1'b0; e_to = 1'b0;
    endtask

    task automatic do_reset(input bit imm);
        reset = 1'b1;
        wclk = 1'b0;
        whold = 1'b0;
        req_valid = 1'b0;
        set_reset_exp();
        #1;
        if (imm) chk("async_reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("in_reset");
        end
        wph = int'($urandom_range(0, 127));
        reset = 1'b0;
    endtask

    // Waits for one awaited edge; a full silent budget counts as the edge.
    task automatic wait_edge(input bit want_rise, input string tag);
        bit ev;
        for (int k = 1; k <= TO; k++) begin
            tick();
            ev = want_rise ? rose : fell;
            if (ev || k == TO) begin
                if (k == TO) e_to = 1'b1;
                break;
            end
            chk(tag);
        end
    endtask

    task automatic settle(input string tag);
        for (int i = 0; i < SETTLE; i++) begin
            wait_edge(1'b1, tag);
            if (i < SETTLE - 1) chk(tag);
        end
        e_mute = 1'b0; e_done = 1'b1; e_ready = 1'b1;
        chk({tag, "_done"});
        tick();
        e_done = 1'b0;
        chk({tag, "_idle"});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            chk("idle");
        end
    endtask

    // abort_at > 0 fires an async reset after that many hold cycles.
    task automatic request(input logic [1:0] r, input int abort_at);
        req_rate = r;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        e_ready = 1'b0;
        if (r == 2'd3) begin
            e_err = 1'b1;
            chk("illegal");
            tick();
            e_err = 1'b0; e_ready = 1'b1;
            chk("illegal_after");
        end else if (r == e_rate) begin
            e_done = 1'b1;
            chk("same_rate");
            tick();
            e_done = 1'b0; e_ready = 1'b1;
            chk("same_after");
        end else begin
            e_mute = 1'b1;
            chk("accept");
            wait_edge(1'b0, "mute_wait");
            whold = 1'b0;
            e_rst = 1'b1; e_rate = r;
            chk("hold");
            for (int i = 1; i < HOLD; i++) begin
                if (i == abort_at) begin
                    do_reset(1'b1);
                    settle("reboot");
                    return;
                end
                tick();
                chk("hold");
            end
            tick();
            e_rst = 1'b0;
            chk("release");
            settle("settle");
        end
    endtask

    initial begin
        logic [1:0] r;
        do_reset(1'b0);
        settle("boot");
        idle(5);
        request(2'd2, 0);
        idle(3);
        request(2'd3, 0);
        request(2'd2, 0);
        idle(2);
        for (int n = 0; n < 8; n++) begin
            r = 2'($urandom_range(0, 3));
            request(r, 0);
            idle(int'($urandom_range(0, 20)));
        end
        for (int i = 0; i < 300 && wclk; i++) begin
            tick();
            chk("idle_low");
        end
        whold = 1'b1;
        r = (e_rate == 2'd0) ? 2'd1 : 2'd0;
        request(r, 0);
        idle(4);
        request(2'd3, 0);
        r = (e_rate == 2'd2) ? 2'd0 : 2'd2;
        request(r, 2);
        idle(3);
        request(2'd1, 0);
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
